id_ex_stage: RTL

- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage 32-bit MIPS pipeline.
- Captures the control bundles from the decode-stage control unit (WB, M, EX) together with decoded operands.
- Presents these fields to the execute stage one cycle later.
- Inserts a bubble and stalls PC and IF/ID on a load-use dependency.
- Zeroes control on a branch flush and freezes on an external hold.

---
 rtl/id_ex_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use hazard
// detection, branch flush, global hold and a saturating bubble counter.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       wb_in,
  input  logic [2:0]       m_in,
  input  logic [3:0]       ex_in,
  input  logic [31:0]      instr_in,
  input  logic [DW-1:0]    rd1_in,
  input  logic [DW-1:0]    rd2_in,
  input  logic [DW-1:0]    imm_in,
  input  logic [DW-1:0]    pc4_in,
  input  logic             valid_in,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       id_ex_wb,
  output logic [2:0]       id_ex_m,
  output logic [3:0]       id_ex_ex,
  output logic [DW-1:0]    id_ex_rd1,
  output logic [DW-1:0]    id_ex_rd2,
  output logic [DW-1:0]    id_ex_imm,
  output logic [DW-1:0]    id_ex_pc4,
  output logic [4:0]       id_ex_rs,
  output logic [4:0]       id_ex_rt,
  output logic [4:0]       id_ex_rd,
  output logic             id_ex_valid,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_count
);

  logic [1:0]       wb_reg;
  logic [2:0]       m_reg;
  logic [3:0]       ex_reg;
  logic [DW-1:0]    rd1_reg, rd2_reg, imm_reg, pc4_reg;
  logic [4:0]       rs_reg, rt_reg, rd_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] count_reg;

  logic [4:0] dec_rs, dec_rt;
  logic       hz;
  logic       ctrl_keep;

  assign dec_rs = instr_in[25:21];
  assign dec_rt = instr_in[20:16];

  // Load in EX (MemRead) whose destination rt is read by the decode instruction.
  assign hz = valid_reg & m_reg[1] & (rt_reg != 5'd0) & valid_in &
              ((rt_reg == dec_rs) | (rt_reg == dec_rt));

  // Control survives only on a normal capture of a real instruction.
  assign ctrl_keep = ~flush & ~hz & valid_in;

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if (rst_n && (flush || (!hold && !hz))) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_reg    <= '0;
      m_reg     <= '0;
      ex_reg    <= '0;
      rd1_reg   <= '0;
      rd2_reg   <= '0;
      imm_reg   <= '0;
      pc4_reg   <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      rd_reg    <= '0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else if (flush || !hold) begin
      wb_reg    <= ctrl_keep ? wb_in : 2'b00;
      m_reg     <= ctrl_keep ? m_in  : 3'b000;
      ex_reg    <= ctrl_keep ? ex_in : 4'b0000;
      valid_reg <= ctrl_keep;
      rd1_reg   <= rd1_in;
      rd2_reg   <= rd2_in;
      imm_reg   <= imm_in;
      pc4_reg   <= pc4_in;
      rs_reg    <= instr_in[25:21];
      rt_reg    <= instr_in[20:16];
      rd_reg    <= instr_in[15:11];
      // A flush wins over the hazard, so only genuine bubbles are counted.
      if (!flush && hz && (count_reg != {CNT_W{1'b1}}))
        count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign id_ex_wb     = wb_reg;
  assign id_ex_m      = m_reg;
  assign id_ex_ex     = ex_reg;
  assign id_ex_rd1    = rd1_reg;
  assign id_ex_rd2    = rd2_reg;
  assign id_ex_imm    = imm_reg;
  assign id_ex_pc4    = pc4_reg;
  assign id_ex_rs     = rs_reg;
  assign id_ex_rt     = rt_reg;
  assign id_ex_rd     = rd_reg;
  assign id_ex_valid  = valid_reg;
  assign bubble_count = count_reg;

endmodule
